// File: rtl/mem_io_decode_stretch.sv
// Address decode, sideways bank select and 1 MHz bus cycle stretcher.
// Slow peripherals hold the CPU until one full 1 MHz access completes.
module mem_io_decode_stretch #(
  parameter int          ROMSEL_W   = 4,
  parameter logic [15:0] SWRAM_MASK = 16'h00F0,
  parameter bit          STRETCH_EN = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [15:0]         cpu_a,
  input  logic                cpu_rnw,
  input  logic [7:0]          cpu_din,
  input  logic                cpu_clken,
  input  logic                mhz1_clken,
  output logic                cpu_ce_out,
  output logic [ROMSEL_W-1:0] romsel,
  output logic                ram_enable,
  output logic                rom_enable,
  output logic                mos_enable,
  output logic                swram_we,
  output logic                io_fred,
  output logic                io_jim,
  output logic                io_sheila,
  output logic [10:0]         dev_sel,
  output logic                periph_ce,
  output logic                stall
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    ACCESS,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0] page;
  logic [7:0] off;
  logic       slow_acc;
  logic       ce;
  logic       pce;
  logic       stl;
  logic [7:0] rs_ext;
  logic       bank_is_ram;
  logic       unused_bits;

  assign page = cpu_a[15:8];
  assign off  = cpu_a[7:0];

  assign ram_enable = ~cpu_a[15];
  assign rom_enable = (cpu_a[15:14] == 2'b10);
  assign io_fred    = (page == 8'hFC);
  assign io_jim     = (page == 8'hFD);
  assign io_sheila  = (page == 8'hFE);
  assign mos_enable = (cpu_a[15:14] == 2'b11)
                    & ~(io_fred | io_jim | io_sheila);

  always_comb begin
    dev_sel = '0;
    if (io_sheila) begin
      unique case (1'b1)
        off[7:3] == 5'h00: dev_sel[0]  = 1'b1;
        off[7:3] == 5'h01: dev_sel[1]  = 1'b1;
        off[7:4] == 4'h1:  dev_sel[2]  = 1'b1;
        off[7:4] == 4'h2:  dev_sel[3]  = 1'b1;
        off[7:4] == 4'h3:  dev_sel[4]  = 1'b1;
        off[7:5] == 3'h2:  dev_sel[5]  = 1'b1;
        off[7:5] == 3'h3:  dev_sel[6]  = 1'b1;
        off[7:5] == 3'h4:  dev_sel[7]  = 1'b1;
        off[7:5] == 3'h5:  dev_sel[8]  = 1'b1;
        off[7:5] == 3'h6:  dev_sel[9]  = 1'b1;
        off[7:5] == 3'h7:  dev_sel[10] = 1'b1;
        default: ;
      endcase
    end
  end

  // Devices clocked from the 1 MHz bus; ROMSEL and VIDPROC run at CPU speed
  assign slow_acc = io_fred | io_jim
                  | dev_sel[0] | dev_sel[1] | dev_sel[2]
                  | dev_sel[5] | dev_sel[6] | dev_sel[9];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ce        = cpu_clken;
    pce       = 1'b0;
    stl       = 1'b0;
    unique case (state)
      IDLE: begin
        if (STRETCH_EN && cpu_clken && slow_acc) begin
          ce        = 1'b0;
          stl       = 1'b1;
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        ce  = 1'b0;
        stl = 1'b1;
        if (mhz1_clken) state_nxt = ACCESS;
      end
      ACCESS: begin
        ce  = 1'b0;
        stl = 1'b1;
        if (mhz1_clken) begin
          pce       = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        stl = 1'b1;
        if (cpu_clken) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_ce_out = reset_n & ce;
  assign periph_ce  = reset_n & pce;
  assign stall      = reset_n & stl;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      romsel <= '0;
    end else if (cpu_ce_out & dev_sel[4] & ~cpu_rnw) begin
      romsel <= cpu_din[ROMSEL_W-1:0];
    end
  end

  // Banks beyond the 16-entry mask are always ROM
  always_comb begin
    rs_ext                 = '0;
    rs_ext[ROMSEL_W-1:0]   = romsel;
    bank_is_ram            = 1'b0;
    if (rs_ext < 8'd16) bank_is_ram = SWRAM_MASK[rs_ext[3:0]];
  end

  assign swram_we = rom_enable & ~cpu_rnw & bank_is_ram;

  assign unused_bits = ^{cpu_a[2:0], cpu_din};

endmodule

// File: tb/tb_mem_io_decode_stretch.sv
// Bench for mem_io_decode_stretch: spec-level model plus directed anchors.
// Compares every cycle on the falling edge.
module tb_mem_io_decode_stretch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic        cpu_rnw;
  logic [7:0]  cpu_din;
  logic        cpu_clken;
  logic        mhz1_clken;

  logic        cpu_ce_out;
  logic [3:0]  romsel;
  logic        ram_enable, rom_enable, mos_enable, swram_we;
  logic        io_fred, io_jim, io_sheila;
  logic [10:0] dev_sel;
  logic        periph_ce, stall;

  logic        ns_ce, ns_ram, ns_rom, ns_mos, ns_sw;
  logic        ns_fred, ns_jim, ns_sheila, ns_pe, ns_stall;
  logic [3:0]  ns_romsel;
  logic [10:0] ns_dev;

  int n_checks = 0;
  int n_errs   = 0;

  localparam logic [15:0] MASK = 16'h00F0;
  localparam int DEV_LO [11] = '{0, 8, 16, 32, 48, 64, 96, 128, 160, 192, 224};

  always #5 clock = ~clock;

  mem_io_decode_stretch u_dut (
    .clock(clock), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_rnw(cpu_rnw),
    .cpu_din(cpu_din), .cpu_clken(cpu_clken), .mhz1_clken(mhz1_clken),
    .cpu_ce_out(cpu_ce_out), .romsel(romsel), .ram_enable(ram_enable),
    .rom_enable(rom_enable), .mos_enable(mos_enable), .swram_we(swram_we),
    .io_fred(io_fred), .io_jim(io_jim), .io_sheila(io_sheila),
    .dev_sel(dev_sel), .periph_ce(periph_ce), .stall(stall)
  );

  mem_io_decode_stretch #(.STRETCH_EN(1'b0)) u_ns (
    .clock(clock), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_rnw(cpu_rnw),
    .cpu_din(cpu_din), .cpu_clken(cpu_clken), .mhz1_clken(mhz1_clken),
    .cpu_ce_out(ns_ce), .romsel(ns_romsel), .ram_enable(ns_ram),
    .rom_enable(ns_rom), .mos_enable(ns_mos), .swram_we(ns_sw),
    .io_fred(ns_fred), .io_jim(ns_jim), .io_sheila(ns_sheila),
    .dev_sel(ns_dev), .periph_ce(ns_pe), .stall(ns_stall)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dev_index(input logic [7:0] o);
    int idx = 0;
    for (int i = 0; i < 11; i++)
      if (int'(o) >= DEV_LO[i]) idx = i;
    return idx;
  endfunction

  // Model: busy = CPU held; seen = 1 MHz strobes counted since stretch start
  bit       m_busy = 0;
  int       m_seen = 0;
  logic [3:0] m_romsel = '0;
  bit       n_busy = 0;
  int       n_seen = 0;
  logic [3:0] n_romsel = '0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy   <= 0;
      m_seen   <= 0;
      m_romsel <= '0;
    end else begin
      m_busy   <= n_busy;
      m_seen   <= n_seen;
      m_romsel <= n_romsel;
    end
  end

  always @(negedge clock) begin
    logic [15:0] a;
    bit fred, jim, sh, ram, rom, mos, slow, e_ce, e_st, e_pe, e_sw;
    int di;
    logic [10:0] e_dev;
    a    = cpu_a;
    ram  = a < 16'h8000;
    rom  = (a >= 16'h8000) && (a < 16'hC000);
    fred = (a >= 16'hFC00) && (a < 16'hFD00);
    jim  = (a >= 16'hFD00) && (a < 16'hFE00);
    sh   = (a >= 16'hFE00) && (a < 16'hFF00);
    mos  = (a >= 16'hC000) && !(fred || jim || sh);
    di   = dev_index(a[7:0]);
    e_dev = sh ? (11'd1 << di) : 11'd0;
    slow = fred || jim || (sh && (di inside {0, 1, 2, 5, 6, 9}));
    if (!reset_n) begin
      e_ce = 0; e_st = 0; e_pe = 0; n_busy = 0; n_seen = 0;
    end else if (!m_busy) begin
      e_st = cpu_clken && slow;
      e_ce = cpu_clken && !slow;
      e_pe = 0;
      n_busy = e_st;
      n_seen = 0;
    end else if (m_seen < 2) begin
      e_st = 1; e_ce = 0;
      e_pe = mhz1_clken && (m_seen == 1);
      n_busy = 1;
      n_seen = m_seen + (mhz1_clken ? 1 : 0);
    end else begin
      e_st = 1; e_ce = cpu_clken; e_pe = 0;
      n_busy = !cpu_clken;
      n_seen = 2;
    end
    if (!reset_n) n_romsel = '0;
    else if (e_ce && sh && di == 4 && !cpu_rnw) n_romsel = cpu_din[3:0];
    else n_romsel = m_romsel;
    e_sw = rom && !cpu_rnw && MASK[m_romsel];
    chk("decode", {ram_enable, rom_enable, mos_enable, io_fred, io_jim, io_sheila},
        {ram, rom, mos, fred, jim, sh});
    chk("dev_sel", dev_sel, e_dev);
    chk("cpu_ce_out", cpu_ce_out, e_ce);
    chk("stall", stall, e_st);
    chk("periph_ce", periph_ce, e_pe);
    chk("romsel", romsel, m_romsel);
    chk("swram_we", swram_we, e_sw);
    chk("ns_ce", ns_ce, reset_n & cpu_clken);
    chk("ns_pe_stall", {ns_pe, ns_stall}, 2'b00);
  end

  task automatic drive(input logic [15:0] a, input logic rnw,
                       input logic [7:0] d, input logic ce, input logic m);
    @(posedge clock);
    #1;
    cpu_a = a; cpu_rnw = rnw; cpu_din = d;
    cpu_clken = ce; mhz1_clken = m;
  endtask

  initial begin
    int pe_n, ce_n, pe_at, ce_at, nspe_n;
    logic [15:0] ra;
    reset_n = 1'b1;
    cpu_a = 16'hFE40; cpu_rnw = 1'b1; cpu_din = 8'h00;
    cpu_clken = 1'b1; mhz1_clken = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_ce", cpu_ce_out, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_periph", periph_ce, 1'b0);
    chk("rst_romsel", romsel, 4'h0);
    chk("rst_dev_sel", dev_sel, 11'h020);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1; cpu_clken = 1'b0; cpu_a = 16'h0000;

    drive(16'hFE30, 1'b0, 8'h3C, 1'b1, 1'b0);
    @(negedge clock);
    chk("romsel_wr_ce", cpu_ce_out, 1'b1);
    chk("romsel_wr_stall", stall, 1'b0);
    drive(16'h0000, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("romsel_C", romsel, 4'hC);

    drive(16'hFE30, 1'b0, 8'h05, 1'b1, 1'b0);
    drive(16'h8123, 1'b0, 8'hAA, 1'b0, 1'b0);
    #1 chk("swram_bank5", swram_we, 1'b1);
    drive(16'hFE30, 1'b0, 8'h00, 1'b1, 1'b0);
    drive(16'h8123, 1'b0, 8'hAA, 1'b0, 1'b0);
    #1 chk("swram_bank0", swram_we, 1'b0);

    pe_n = 0; ce_n = 0; pe_at = -1; ce_at = -1; nspe_n = 0;
    for (int c = 0; c < 56; c++) begin
      drive(c < 50 ? 16'hFE40 : 16'h0000, 1'b1, 8'h00,
            (c % 16 == 0) && (c < 50), c % 32 == 7);
      @(negedge clock);
      if (c == 0) begin
        chk("sysvia_entry_stall", stall, 1'b1);
        chk("sysvia_entry_ce", cpu_ce_out, 1'b0);
        chk("ns_entry_ce", ns_ce, 1'b1);
      end
      if (c == 48) chk("sysvia_done_stall", stall, 1'b1);
      if (c == 49) chk("sysvia_after_stall", stall, 1'b0);
      if (periph_ce) begin pe_n++; pe_at = c; end
      if (cpu_ce_out && ce_at < 0) ce_at = c;
      if (cpu_ce_out) ce_n++;
      if (ns_pe) nspe_n++;
    end
    chk("sysvia_pe_count", pe_n, 1);
    chk("sysvia_pe_cycle", pe_at, 39);
    chk("sysvia_ce_count", ce_n, 1);
    chk("sysvia_ce_cycle", ce_at, 48);
    chk("ns_pe_count", nspe_n, 0);

    pe_at = -1;
    drive(16'hFE40, 1'b1, 8'h00, 1'b1, 1'b1);
    for (int c = 1; c < 26; c++) begin
      drive(16'hFE40, 1'b1, 8'h00, c == 24, c % 10 == 0);
      @(negedge clock);
      if (periph_ce && pe_at < 0) pe_at = c;
    end
    chk("entry_strobe_ignored", pe_at, 20);

    for (int i = 0; i < 256; i++) begin
      drive(16'hFE00 + 16'(i), 1'b1, 8'h00, 1'b0, 1'b0);
      if (i == 8'h0F) #1 chk("dev_acia", dev_sel, 11'h002);
      if (i == 8'h30) #1 chk("dev_romsel", dev_sel, 11'h010);
      if (i == 8'hE5) #1 chk("dev_tube", dev_sel, 11'h400);
    end
    drive(16'hFD00, 1'b1, 8'h00, 1'b0, 1'b0);
    #1 chk("jim_page", {io_jim, dev_sel}, {1'b1, 11'h000});

    drive(16'hFE30, 1'b0, 8'h09, 1'b1, 1'b0);
    drive(16'hFE40, 1'b1, 8'h00, 1'b1, 1'b0);
    drive(16'hFE40, 1'b1, 8'h00, 1'b0, 1'b1);
    drive(16'hFE40, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("access_stall", stall, 1'b1);
    chk("access_romsel", romsel, 4'h9);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_stall", stall, 1'b0);
    chk("abort_romsel", romsel, 4'h0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    drive(16'hFC00, 1'b1, 8'h00, 1'b1, 1'b0);
    @(negedge clock);
    chk("fred_restretch_stall", stall, 1'b1);
    chk("fred_restretch_ce", cpu_ce_out, 1'b0);
    for (int c = 0; c < 40; c++)
      drive(16'hFC00, 1'b1, 8'h00, c % 8 == 3, c % 5 == 0);

    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 7))
        0: ra = 16'($urandom_range(0, 16'h7FFF));
        1: ra = 16'h8000 + 16'($urandom_range(0, 16'h3FFF));
        2: ra = 16'hC000 + 16'($urandom_range(0, 16'h3BFF));
        3: ra = {8'hFC, 8'($urandom)};
        4: ra = {8'hFD, 8'($urandom)};
        5, 6: ra = {8'hFE, 8'($urandom)};
        default: ra = 16'hFE30 + 16'($urandom_range(0, 15));
      endcase
      drive(ra, 1'($urandom), 8'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset_n = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;
      end
    end

    drive(16'h0000, 1'b1, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
